counter_sweep_ctrl: RTL and testbench
=====================================

Name: counter_sweep_ctrl

Overview:
- Sequencer for the team's WIDTH-bit up/down counter: owns that counter's rst and en inputs.
  - Counter interface: en=0 means +1 per clock, en=1 means -1 per clock, rst clears it synchronously.
- Drives the counter as a triangle sweep 0 -> hi -> 0, repeated for a programmed number of periods, then parks it at 0.
- Observes the counter's count output and handshakes with a host through start/ready/done.

Parameters:
- WIDTH, 8, width of the controlled counter and of hi/count_in.
- PW, 8, width of n_periods and period_cnt.

Ports:
- clk  input  1  clock; shared with the controlled counter.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; accepted only when start & ready.
- abort  input  1  terminate any sweep immediately.
- hi  input  WIDTH  sweep peak; sampled on accept.
- n_periods  input  PW  number of triangle periods; sampled on accept.
- count_in  input  WIDTH  counter's count output.
- cnt_rst  output  1  drives counter rst.
- cnt_en  output  1  drives counter en (1 = decrement, 0 = increment).
- ready  output  1  idle and counter at 0; start may be accepted.
- busy  output  1  sweep in progress (state != IDLE).
- peak  output  1  state UP and count_in == hi_q (combinational).
- period_cnt  output  PW  completed periods of current/last sweep.
- done  output  1  one-cycle registered pulse on normal completion.

Behaviour:
- One clock, clk. rst is synchronous, active-high; all registers update on posedge clk.
- Reset values: state=IDLE, hi_q=0, n_q=0, period_cnt=0, done=0.
- Combinational outputs after reset: cnt_rst=1, cnt_en=0, busy=0.
- ready=0 until count_in==0. The counter clears one edge after cnt_rst is seen, so ready rises one cycle after reset.

States:
- IDLE
  - cnt_rst=1, cnt_en=0, ready = (count_in==0).
  - Accept when start & ready & hi!=0 & n_periods!=0: latch hi_q, n_q, clear period_cnt, go UP.
  - Accept with hi==0 or n_periods==0: ignored; no state change, no done.
- UP
  - cnt_rst=0.
  - If count_in==hi_q: cnt_en=1, go DOWN. Otherwise cnt_en=0, stay.
- DOWN
  - cnt_rst=0.
  - If count_in!=0: cnt_en=1, stay.
  - If count_in==0: period_cnt <= period_cnt+1.
    - If period_cnt+1 == n_q: cnt_rst=1, go IDLE, done<=1 (high in first IDLE cycle).
    - Otherwise: cnt_en=0, go UP.

Timing and boundary rules:
- cnt_rst and cnt_en are combinational from state and count_in, so the counter never exceeds hi_q and never wraps below 0.
- Latency: first count change appears one cycle after accept.
- Each period is 2*hi_q cycles. busy stays high for exactly 2*hi_q*n_q + 1 cycles.
- hi and n_periods changes while busy are ignored. start while busy is ignored.
- abort (any non-IDLE state): next state IDLE, cnt_rst=1 that cycle, no done, period_cnt holds its value.
  - abort in IDLE: no effect.
  - abort and start in the same cycle: abort wins, sweep not accepted.
- rst mid-sweep: IDLE, cnt_rst=1, period_cnt=0, no done. Counter is 0 two edges later.
- hi_q = 2^WIDTH-1 is legal: peak is reached without wrap.
- period_cnt holds after done until the next accept.
- done is 0 in every cycle except the single completion pulse.

Test Plan:
- Reset, idle: rst 1 cycle -> cnt_rst=1, count_in 0 next cycle, ready=1, busy=0, done=0.
- Single period: hi=3, n=1 -> counter 1,2,3,2,1,0 on successive cycles.
  - peak high exactly one cycle (count 3).
  - busy 7 cycles; done pulses once; period_cnt=1; counter stays 0.
- Multi-period: hi=2, n=3 -> sequence 1,2,1,0 repeated 3 times.
  - period_cnt steps 1,2,3; busy 13 cycles; single done.
- Full range: WIDTH=8, hi=255, n=1 -> counter reaches 255, never 0 from 255.
  - Returns to 0 after 510 cycles; done pulses.
- Abort: hi=10, n=2, abort when count_in=7 (rising, period 1).
  - Next cycle state IDLE, counter 0, no done, period_cnt=0.
  - start with hi=0 -> ignored, busy stays 0.
- Reset mid-sweep and collisions: rst at count 5 -> IDLE, period_cnt=0, no done.
  - start during busy has no effect.
  - Simultaneous abort+start in IDLE -> not accepted.

Source files
------------

// File: rtl/counter_sweep_ctrl.sv
// Drives an external up/down counter through hi-peak triangle sweeps, n_periods times, then parks it at 0.
// Latency: first count change one cycle after accept; cnt_rst/cnt_en are combinational from state and count_in.
// Backpressure: start is taken only when ready; start/hi/n_periods are ignored while busy; abort always wins.
module counter_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int PW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] hi,
  input  logic [PW-1:0]    n_periods,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_rst,
  output logic             cnt_en,
  output logic             ready,
  output logic             busy,
  output logic             peak,
  output logic [PW-1:0]    period_cnt,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [PW-1:0]    n_q, n_d;
  logic [PW-1:0]    period_cnt_q, period_cnt_d;
  logic             done_q, done_d;

  logic             count_zero;
  logic             at_peak;
  logic [PW-1:0]    period_inc;
  logic             last_period;
  logic             accept;

  assign count_zero  = (count_in == '0);
  assign at_peak     = (count_in == hi_q);
  assign period_inc  = period_cnt_q + 1'b1;
  assign last_period = (period_inc == n_q);
  // abort outranks a same-cycle start; zero peak or zero periods are silently dropped
  assign accept      = (state_q == IDLE) && start && count_zero && !abort
                       && (hi != '0) && (n_periods != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hi_q         <= '0;
      n_q          <= '0;
      period_cnt_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      n_q          <= n_d;
      period_cnt_q <= period_cnt_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    n_d          = n_q;
    period_cnt_d = period_cnt_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = UP;
          hi_d         = hi;
          n_d          = n_periods;
          period_cnt_d = '0;
        end
      end
      UP: begin
        if (abort)        state_d = IDLE;
        else if (at_peak) state_d = DOWN;
      end
      DOWN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (count_zero) begin
          period_cnt_d = period_inc;
          if (last_period) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = UP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter direction is decided in the same cycle count_in is seen, so it never overshoots hi_q or 0.
  always_comb begin
    cnt_rst = 1'b1;
    cnt_en  = 1'b0;
    case (state_q)
      UP: begin
        if (!abort) begin
          cnt_rst = 1'b0;
          cnt_en  = at_peak;
        end
      end
      DOWN: begin
        if (!abort && !(count_zero && last_period)) begin
          cnt_rst = 1'b0;
          cnt_en  = !count_zero;
        end
      end
      default: begin
        cnt_rst = 1'b1;
        cnt_en  = 1'b0;
      end
    endcase
  end

  assign ready      = (state_q == IDLE) && count_zero;
  assign busy       = (state_q != IDLE);
  assign peak       = (state_q == UP) && at_peak;
  assign period_cnt = period_cnt_q;
  assign done       = done_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: behavioural up/down counter in the loop, expected sweep samples queued per accept.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] hi, n_periods;
  logic [7:0] cnt = 8'h55;
  logic       cnt_rst, cnt_en, ready, busy, peak, done;
  logic [7:0] period_cnt;

  typedef struct {int c; int pc;} exp_t;
  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // The controlled counter: en=0 counts up, en=1 counts down, rst clears.
  always @(posedge clk) begin
    if (cnt_rst)     cnt <= 8'd0;
    else if (cnt_en) cnt <= cnt - 8'd1;
    else             cnt <= cnt + 8'd1;
  end

  counter_sweep_ctrl #(.WIDTH(8), .PW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .hi(hi), .n_periods(n_periods), .count_in(cnt),
    .cnt_rst(cnt_rst), .cnt_en(cnt_en), .ready(ready), .busy(busy),
    .peak(peak), .period_cnt(period_cnt), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_sweep(input int h, input int n);
    exp_q.push_back('{0, 0});
    for (int p = 0; p < n; p++) begin
      for (int c = 1; c <= h; c++)     exp_q.push_back('{c, p});
      for (int c = h - 1; c >= 0; c--) exp_q.push_back('{c, p});
    end
  endtask

  // Returns at the negedge of the first busy cycle (count still 0).
  task automatic do_start(input int h, input int n);
    @(negedge clk);
    start     = 1'b1;
    hi        = 8'(h);
    n_periods = 8'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic watch(input string tag, input int h, input int n, input int poke_at);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '{-1, -1};
      chk({tag, "_count"}, 32'(cnt), e.c);
      chk({tag, "_period_cnt"}, 32'(period_cnt), e.pc);
      chk({tag, "_peak"}, 32'(peak), 32'(e.c == h));
      chk({tag, "_done_low"}, 32'(done), 0);
      if (cyc == poke_at) begin
        start     = 1'b1;
        hi        = 8'd7;
        n_periods = 8'd9;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, cyc, 2 * h * n + 1);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
    chk({tag, "_done_pulse"}, 32'(done), 1);
    chk({tag, "_final_periods"}, 32'(period_cnt), n);
    chk({tag, "_parked"}, 32'(cnt), 0);
    chk({tag, "_ready"}, 32'(ready), 1);
    exp_q.delete();
    @(negedge clk);
    chk({tag, "_done_once"}, 32'(done), 0);
    chk({tag, "_still_parked"}, 32'(cnt), 0);
    chk({tag, "_periods_hold"}, 32'(period_cnt), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; hi = 8'd0; n_periods = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_cnt_rst", 32'(cnt_rst), 1);
    chk("rst_cnt_en", 32'(cnt_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_period_cnt", 32'(period_cnt), 0);
    @(negedge clk);
    chk("rst_count_cleared", 32'(cnt), 0);
    chk("rst_ready", 32'(ready), 1);

    push_sweep(3, 1);
    do_start(3, 1);
    watch("single", 3, 1, -1);

    push_sweep(2, 3);
    do_start(2, 3);
    watch("multi", 2, 3, 4);

    push_sweep(255, 1);
    do_start(255, 1);
    watch("full", 255, 1, 100);

    // abort while rising in the first period
    do_start(10, 2);
    for (int i = 0; i < 40 && cnt != 8'd7; i++) @(negedge clk);
    chk("abort_reach7", 32'(cnt), 7);
    abort = 1'b1;
    #1;
    chk("abort_cnt_rst", 32'(cnt_rst), 1);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_count", 32'(cnt), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_period_cnt", 32'(period_cnt), 0);

    do_start(0, 1);
    chk("hi0_ignored", 32'(busy), 0);
    chk("hi0_no_done", 32'(done), 0);
    do_start(4, 0);
    chk("n0_ignored", 32'(busy), 0);

    // abort in the second period: period_cnt must hold
    do_start(2, 3);
    for (int i = 0; i < 40 && !(period_cnt == 8'd1 && cnt == 8'd2); i++) @(negedge clk);
    chk("abort2_reach", 32'(period_cnt), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort2_busy", 32'(busy), 0);
    chk("abort2_period_hold", 32'(period_cnt), 1);
    chk("abort2_done", 32'(done), 0);
    chk("abort2_count", 32'(cnt), 0);

    // synchronous reset mid-sweep
    do_start(6, 2);
    for (int i = 0; i < 60 && !(period_cnt == 8'd1 && cnt == 8'd5); i++) @(negedge clk);
    chk("rstmid_reach", 32'(cnt), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_period_cnt", 32'(period_cnt), 0);
    chk("rstmid_done", 32'(done), 0);
    chk("rstmid_count_lag", 32'(cnt), 6);
    chk("rstmid_not_ready", 32'(ready), 0);
    @(negedge clk);
    chk("rstmid_count_zero", 32'(cnt), 0);
    chk("rstmid_ready", 32'(ready), 1);
    chk("rstmid_done2", 32'(done), 0);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    abort = 1'b1; start = 1'b1; hi = 8'd3; n_periods = 8'd1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("collide_busy", 32'(busy), 0);
    chk("collide_done", 32'(done), 0);
    @(negedge clk);
    chk("collide_still_idle", 32'(busy), 0);

    push_sweep(1, 2);
    do_start(1, 2);
    watch("tiny", 1, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
